// File: rtl/xosera_pkg.sv
// Shared Xosera types: VRAM address/word types and the rectangle-fill engine state.
package xosera_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    localparam int BLIT_FILL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } blit_fill_state_t;

endpackage

// File: rtl/blit_fill.sv
// Rectangular VRAM fill engine: writes one fill word per arbiter grant over a
// width x height rectangle with a programmable line stride.
module blit_fill
    import xosera_pkg::*;
#(
    parameter int CNT_W = BLIT_FILL_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  addr_t            dst_addr_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] height_i,
    input  addr_t            stride_i,
    input  word_t            data_i,
    input  logic [3:0]       wr_mask_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             blit_sel_o,
    output logic             blit_wr_o,
    output logic [3:0]       blit_wr_mask_o,
    output addr_t            blit_addr_o,
    output word_t            blit_data_o,
    input  logic             blit_ack_i
);

    blit_fill_state_t state_q, state_d;
    addr_t            line_addr_q, line_addr_d;
    addr_t            cur_addr_q, cur_addr_d;
    addr_t            stride_q, stride_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_last_q, col_last_d;
    word_t            data_q, data_d;
    logic [3:0]       mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sel_q, sel_d;

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        cur_addr_d  = cur_addr_q;
        stride_d    = stride_q;
        col_d       = col_q;
        row_d       = row_q;
        col_last_d  = col_last_q;
        data_d      = data_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sel_d       = sel_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (width_i != '0 && height_i != '0) begin
                        line_addr_d = dst_addr_i;
                        cur_addr_d  = dst_addr_i;
                        stride_d    = stride_i;
                        col_last_d  = width_i - 1'b1;
                        col_d       = width_i - 1'b1;
                        row_d       = height_i - 1'b1;
                        data_d      = data_i;
                        mask_d      = wr_mask_i;
                        sel_d       = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                // The write for an ack already happened on the grant cycle, so
                // abort simply drops the request without another step.
                if (abort_i) begin
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (blit_ack_i) begin
                    if (col_q != '0) begin
                        cur_addr_d = cur_addr_q + 16'd1;
                        col_d      = col_q - 1'b1;
                    end else if (row_q != '0) begin
                        line_addr_d = line_addr_q + stride_q;
                        cur_addr_d  = line_addr_q + stride_q;
                        col_d       = col_last_q;
                        row_d       = row_q - 1'b1;
                    end else begin
                        sel_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                sel_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            cur_addr_q  <= '0;
            stride_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            col_last_q  <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cur_addr_q  <= cur_addr_d;
            stride_q    <= stride_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_last_q  <= col_last_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_q       <= sel_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign blit_sel_o     = sel_q;
    assign blit_wr_o      = sel_q;
    assign blit_wr_mask_o = mask_q;
    assign blit_addr_o    = cur_addr_q;
    assign blit_data_o    = data_q;

endmodule

// File: tb/tb_blit_fill.sv
// Directed and randomized bench for blit_fill with an arbiter model and a
// rectangle address reference model.
module tb_blit_fill;
    import xosera_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    addr_t       dst_addr_i = '0;
    logic [15:0] width_i = '0;
    logic [15:0] height_i = '0;
    addr_t       stride_i = '0;
    word_t       data_i = '0;
    logic [3:0]  wr_mask_i = '0;
    logic        busy_o, done_o, blit_sel_o, blit_wr_o;
    logic [3:0]  blit_wr_mask_o;
    addr_t       blit_addr_o;
    word_t       blit_data_o;
    logic        blit_ack_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    blit_fill #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
        .dst_addr_i(dst_addr_i), .width_i(width_i), .height_i(height_i),
        .stride_i(stride_i), .data_i(data_i), .wr_mask_i(wr_mask_i),
        .busy_o(busy_o), .done_o(done_o), .blit_sel_o(blit_sel_o),
        .blit_wr_o(blit_wr_o), .blit_wr_mask_o(blit_wr_mask_o),
        .blit_addr_o(blit_addr_o), .blit_data_o(blit_data_o),
        .blit_ack_i(blit_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one command from start to done (or abort), acting as the arbiter:
    // grant whenever sel is high outside an ack cycle, ack the cycle after.
    task automatic run_fill(input addr_t dst, input int w, input int h, input addr_t stride,
                            input word_t data, input logic [3:0] mask,
                            input int stall_word, input int stall_len, input int abort_after);
        addr_t exp_q[$];
        int n, exp_done, cyc, writes, acks, stall_rem, abort_cyc;
        bit grant_prev, grant;
        exp_q = {};
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back(16'(int'(dst) + r * int'(stride) + c));
        n = w * h;
        exp_done = (n == 0) ? 1 : 2 * n + 1 + ((stall_word < n) ? stall_len : 0);

        dst_addr_i = dst; width_i = 16'(w); height_i = 16'(h);
        stride_i = stride; data_i = data; wr_mask_i = mask;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1; writes = 0; acks = 0; stall_rem = stall_len; abort_cyc = 0; grant_prev = 0;

        while (cyc <= 400) begin
            check("wr_follows_sel", blit_wr_o, blit_sel_o);
            if (abort_cyc != 0) begin
                check("abort_sel", blit_sel_o, 1'b0);
                check("abort_busy", busy_o, 1'b0);
                check("abort_no_done", done_o, 1'b0);
                if (cyc >= abort_cyc + 4) break;
            end else begin
                check("busy", busy_o, (n > 0 && cyc < exp_done));
                check("done", done_o, (cyc == exp_done));
                if (n == 0) check("zero_no_sel", blit_sel_o, 1'b0);
                if (cyc == exp_done) break;
            end
            grant = 0;
            if (blit_sel_o && !grant_prev) begin
                if (writes == stall_word && stall_rem > 0) begin
                    stall_rem--;
                    if (exp_q.size() > 0) check("stall_addr_held", blit_addr_o, exp_q[0]);
                end else begin
                    grant = 1;
                    check("write_in_range", 32'(writes < n), 1);
                    if (exp_q.size() > 0) check("addr", blit_addr_o, exp_q.pop_front());
                    check("data", blit_data_o, data);
                    check("mask", blit_wr_mask_o, mask);
                    writes++;
                end
            end
            blit_ack_i = grant_prev;
            if (grant_prev) acks++;
            abort_i = (abort_after >= 0 && grant_prev && acks == abort_after);
            if (abort_i) abort_cyc = cyc;
            grant_prev = grant;
            @(posedge clk); #1;
            abort_i = 1'b0;
            cyc++;
        end
        blit_ack_i = 1'b0;
        check("loop_in_budget", 32'(cyc <= 400), 1);
        check("write_count", writes, (abort_after >= 0) ? abort_after : n);
        @(posedge clk); #1;
        check("idle_after", busy_o | blit_sel_o | done_o, 1'b0);
    endtask

    initial begin
        #3;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_sel", blit_sel_o, 1'b0);
        check("rst_wr", blit_wr_o, 1'b0);
        check("rst_addr", blit_addr_o, 16'h0);
        check("rst_data", blit_data_o, 16'h0);
        check("rst_mask", blit_wr_mask_o, 4'h0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        run_fill(16'h1000, 3, 2, 16'h0040, 16'hA5A5, 4'hF, 99, 0, -1);
        run_fill(16'h1000, 3, 2, 16'h0040, 16'hA5A5, 4'hF, 1, 5, -1);
        run_fill(16'h2000, 0, 4, 16'h0010, 16'h1234, 4'h3, 99, 0, -1);
        run_fill(16'h2000, 5, 0, 16'h0010, 16'h1234, 4'h3, 99, 0, -1);
        run_fill(16'hFFFE, 3, 2, 16'h0100, 16'h5A5A, 4'h9, 99, 0, -1);
        run_fill(16'h0100, 2, 3, 16'hFFF0, 16'h0F0F, 4'hC, 99, 0, -1);
        run_fill(16'h3000, 4, 4, 16'h0020, 16'hBEEF, 4'hF, 99, 0, 5);
        run_fill(16'h4000, 1, 1, 16'h0020, 16'hCAFE, 4'h7, 99, 0, -1);

        for (int k = 0; k < 8; k++) begin
            int w, h, sw;
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
            sw = $urandom_range(0, w * h - 1);
            run_fill(16'($urandom), w, h, 16'($urandom), 16'($urandom), 4'($urandom),
                     sw, $urandom_range(0, 3), -1);
        end

        // Reset in the middle of a fill, then a stale ack after release.
        dst_addr_i = 16'h5000; width_i = 16'd4; height_i = 16'd4;
        stride_i = 16'h0040; data_i = 16'h7777; wr_mask_i = 4'hF;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("pre_reset_sel", blit_sel_o, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_sel", blit_sel_o, 1'b0);
        check("async_rst_wr", blit_wr_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_done", done_o, 1'b0);
        check("async_rst_addr", blit_addr_o, 16'h0);
        check("async_rst_data", blit_data_o, 16'h0);
        check("async_rst_mask", blit_wr_mask_o, 4'h0);
        blit_ack_i = 1'b1;
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("stale_ack_sel", blit_sel_o, 1'b0);
        check("stale_ack_busy", busy_o, 1'b0);
        check("stale_ack_done", done_o, 1'b0);
        blit_ack_i = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", busy_o | blit_sel_o | done_o, 1'b0);
        run_fill(16'h6000, 1, 1, 16'h0001, 16'h4242, 4'h5, 99, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
